// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and an
// optional 2-entry skid buffer. Main entry M feeds the outputs; S catches a beat that arrives while M is stalled.
module pipe_stage_skid_reg #(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter int                 TAG_W     = 4,
    parameter int                 SKID_EN   = 1,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [TAG_W-1:0]   out_tag,
    output logic [1:0]         occupancy
);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [TAG_W-1:0]   tag;
    } beat_t;

    localparam beat_t EMPTY_BEAT = '{pc: '0, instr: NOP_INSTR, tag: '0};

    logic  m_valid, s_valid;
    logic  m_valid_n, s_valid_n;
    beat_t m_q, s_q, m_n, s_n;
    beat_t in_beat;
    logic  [1:0] occ_q, occ_n;
    logic  in_fire, out_fire;

    assign in_beat  = '{pc: in_pc, instr: in_instr, tag: in_tag};

    // Skid mode takes ready straight from a flop; plain mode lets a draining beat make room in the same cycle.
    assign in_ready = (SKID_EN != 0) ? ~s_valid : (~m_valid | out_ready);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = m_valid & out_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
        m_valid_n = m_valid;
        s_valid_n = s_valid;
        m_n       = m_q;
        s_n       = s_q;
        if (flush) begin
            m_valid_n = 1'b0;
            s_valid_n = 1'b0;
            m_n       = EMPTY_BEAT;
            s_n       = EMPTY_BEAT;
        end else if (out_fire) begin
            if (s_valid) begin
                m_n       = s_q;
                s_valid_n = 1'b0;
                s_n       = EMPTY_BEAT;
            end else if (in_fire) begin
                m_n = in_beat;
            end else begin
                m_valid_n = 1'b0;
                m_n       = EMPTY_BEAT;
            end
        end else if (in_fire) begin
            if (!m_valid) begin
                m_valid_n = 1'b1;
                m_n       = in_beat;
            end else if (SKID_EN != 0) begin
                s_valid_n = 1'b1;
                s_n       = in_beat;
            end
        end
        occ_n = {1'b0, m_valid_n} + {1'b0, s_valid_n};
    end

    // NOTE: payload registers are reset too, because an empty stage must present the NOP bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_q     <= EMPTY_BEAT;
            s_q     <= EMPTY_BEAT;
            occ_q   <= 2'd0;
        end else begin
            m_valid <= m_valid_n;
            s_valid <= s_valid_n;
            m_q     <= m_n;
            s_q     <= s_n;
            occ_q   <= occ_n;
        end
    end

    assign out_valid = m_valid;
    assign out_pc    = m_q.pc;
    assign out_instr = m_q.instr;
    assign out_tag   = m_q.tag;
    assign occupancy = occ_q;

endmodule
